alu_issuer: RTL
===============

ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles spent in WAIT before aborting an operation.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  issuer can accept a command.
REQ-006 cmd_op  input  3  opcode: ADD, SUB, MUL, DIV, AND, OR, XOR (000..110).
REQ-007 cmd_a, cmd_b  input  8 each  signed operands.
REQ-008 alu_start  output  1  one-cycle start pulse to the ALU.
REQ-009 alu_op, alu_a, alu_b  output  3/8/8  registered command fields driven to the ALU.
REQ-010 alu_done  input  1  ALU completion level; completion is defined as its rising edge.
REQ-011 alu_result  input  16  ALU result, valid on the alu_done rising-edge cycle.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  downstream accepts the response.
REQ-014 rsp_result, rsp_op  output  16/3  captured result and the opcode that produced it.
REQ-015 rsp_timeout  output  1  the response is an abort, not an ALU result.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 ops_done  output  8  count of responses handed off.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid&cmd_ready at a rising edge.
REQ-020 A handshake SHALL register cmd_op/cmd_a/cmd_b into alu_op/alu_a/alu_b and move the FSM IDLE->ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle with alu_start=1, then go to WAIT.
REQ-022 alu_start SHALL be 0 in every other state.
REQ-023 alu_op/alu_a/alu_b SHALL stay stable from ISSUE until the FSM leaves WAIT.
REQ-024 A done_prev register SHALL sample alu_done every cycle in all states; rise = alu_done & ~done_prev.
REQ-025 Only a rise observed in WAIT SHALL count, so done held high from an earlier operation is ignored.
REQ-026 On a WAIT rise, the block SHALL capture alu_result into rsp_result, clear rsp_timeout, and go to RESP; rsp_valid=1 in the next cycle.
REQ-027 wait_cnt SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 When wait_cnt reaches TIMEOUT_CYCLES-1 without a rise, the block SHALL go to RESP with rsp_result=0 and rsp_timeout=1.
REQ-029 If a rise and the timeout occur in the same cycle, the rise SHALL win.
REQ-030 In RESP, rsp_valid=1 and rsp_result/rsp_op/rsp_timeout SHALL hold stable until rsp_valid&rsp_ready.
REQ-031 On that handshake the FSM SHALL return to IDLE and ops_done SHALL increment, wrapping 255->0.
REQ-032 A new command SHALL NOT be accepted in the handshake cycle; the minimum accept-to-accept interval is 4 cycles.
REQ-033 Latency SHALL be: accept at edge N; alu_start high in cycle N+1; a rise seen in cycle M gives rsp_valid from cycle M+1.
REQ-034 rsp_result SHALL pass alu_result through unmodified; the block performs no width or sign manipulation.

Reset
REQ-035 While reset=0: state=IDLE; alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_op, rsp_timeout, busy, ops_done, wait_cnt and done_prev SHALL all be 0, and cmd_ready SHALL be 1.
REQ-036 Assertion of reset SHALL take effect immediately, regardless of clk.
REQ-037 A reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL drop the operation silently, with no response.
REQ-038 Release of reset SHALL be synchronised externally; the first accept is possible at the first rising edge after release.

Structure
REQ-039 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD=000 ... OP_XOR=110), the issuer state encoding, and the default TIMEOUT_CYCLES.
REQ-040 The rise detector and timeout counter SHALL be a single sub-module, alu_done_watch (inputs: clk, reset, alu_done, arm; outputs: rise, expired).

Verification (bench uses a behavioural ALU model with programmable latency)
REQ-041 ADD a=0x7F, b=0x01, model done after 3 cycles with result 0x0080 -> alu_start exactly 1 cycle, in the cycle after accept; rsp_valid 1 cycle after the done rise; rsp_result=0x0080, rsp_op=000, rsp_timeout=0; ops_done=1.
REQ-042 MUL a=-10, b=10, result 0xFF9C, rsp_ready held low 5 cycles -> rsp_valid and rsp_result=0xFF9C stable all 5 cycles; cmd_ready=0 while cmd_valid is held; no second alu_start.
REQ-043 TIMEOUT_CYCLES=8, model never raises done -> RESP entered after 8 WAIT cycles; rsp_timeout=1, rsp_result=0x0000.
REQ-044 alu_done left high after op 1, op 2 = DIV 100/-10 -> no response until done falls and rises again; rsp_result=0xFFF6.
REQ-045 reset pulsed low during WAIT -> all outputs 0 at once, cmd_ready=1; a late done rise from the model produces no rsp_valid.
REQ-046 256 back-to-back XOR ops with rsp_ready=1 -> ops_done reads 0 after the 256th handshake; accept spacing is exactly 4 cycles with 1-cycle ALU latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: opcodes, issuer state encoding and
// the default WAIT timeout.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } issuer_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/alu_issuer_if.sv
// Command, ALU and response signals of the issuer bundled as one interface.
// master = issuer side, slave = upstream/ALU/downstream environment side.
interface alu_issuer_if;
    import alu_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    alu_op_e     cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    logic        alu_start;
    alu_op_e     alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    alu_op_e     rsp_op;
    logic        rsp_timeout;

    logic        busy;
    logic [7:0]  ops_done;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_start, alu_op, alu_a, alu_b,
               rsp_valid, rsp_result, rsp_op, rsp_timeout, busy, ops_done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_start, alu_op, alu_a, alu_b,
               rsp_valid, rsp_result, rsp_op, rsp_timeout, busy, ops_done
    );

endinterface

// File: rtl/alu_done_watch.sv
// Rising-edge detector on alu_done plus the WAIT timeout counter.
// Both are only meaningful while arm is high; the counter restarts at 0 each time arm rises.
module alu_done_watch
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic alu_done,
    input  logic arm,
    output logic rise,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             done_prev_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        if (arm) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // done_prev runs in every state so a level left high by an earlier op never looks like a rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_prev_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            done_prev_q <= alu_done;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign rise    = arm & alu_done & ~done_prev_q;
    assign expired = arm & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_issuer.sv
// Single-outstanding command issuer: accepts one command, starts the ALU,
// waits for completion or timeout, and holds the response until taken.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    alu_issuer_if.master bus
);

    issuer_state_e state_q;
    issuer_state_e state_d;

    alu_op_e     alu_op_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [15:0] rsp_result_q;
    alu_op_e     rsp_op_q;
    logic        rsp_timeout_q;
    logic [7:0]  ops_done_q;

    logic cmd_ready;
    logic alu_start;
    logic rsp_valid;
    logic busy;
    logic accept;
    logic rsp_hs;
    logic wait_arm;
    logic done_rise;
    logic wait_expired;

    alu_done_watch #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_done_watch (
        .clk      (clk),
        .reset    (reset),
        .alu_done (bus.alu_done),
        .arm      (wait_arm),
        .rise     (done_rise),
        .expired  (wait_expired)
    );

    assign wait_arm = (state_q == ST_WAIT);
    assign accept   = bus.cmd_valid & cmd_ready;
    assign rsp_hs   = rsp_valid & bus.rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_rise || wait_expired) state_d = ST_RESP;
            ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_ISSUE: alu_start = 1'b1;
            ST_RESP:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    // A rise in the same cycle as expiry is a real result, so it takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op_q      <= OP_ADD;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_result_q  <= '0;
            rsp_op_q      <= OP_ADD;
            rsp_timeout_q <= 1'b0;
            ops_done_q    <= '0;
        end else begin
            if (accept) begin
                alu_op_q <= bus.cmd_op;
                alu_a_q  <= bus.cmd_a;
                alu_b_q  <= bus.cmd_b;
            end
            if (wait_arm && done_rise) begin
                rsp_result_q  <= bus.alu_result;
                rsp_op_q      <= alu_op_q;
                rsp_timeout_q <= 1'b0;
            end else if (wait_arm && wait_expired) begin
                rsp_result_q  <= '0;
                rsp_op_q      <= alu_op_q;
                rsp_timeout_q <= 1'b1;
            end
            if (rsp_hs) begin
                ops_done_q <= ops_done_q + 8'd1;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.alu_start   = alu_start;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_op      = rsp_op_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy;
    assign bus.ops_done    = ops_done_q;

endmodule
